// File: rtl/tri_bus_pkg.sv
// Shared definitions for the tri-state bus arbiter family: FSM encoding and
// the channel-index width rule used by every block that carries an owner index.
package tri_bus_pkg;

  typedef logic [1:0] bus_state_t;

  localparam bus_state_t ST_IDLE  = 2'd0;
  localparam bus_state_t ST_DRIVE = 2'd1;
  localparam bus_state_t ST_TURN  = 2'd2;

  // A single channel still needs a 1-bit index so port widths never collapse to zero.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans req starting at rr_ptr, wrapping
// modulo NUM_CH, and returns the first requester as one-hot plus binary index.
module rr_arbiter
  import tri_bus_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] win_onehot,
  output logic [CH_W-1:0]   win_idx,
  output logic              win_any
);

  logic [CH_W-1:0] k;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_any    = 1'b0;
    k          = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!win_any && req[k]) begin
        win_any       = 1'b1;
        win_onehot[k] = 1'b1;
        win_idx       = k;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus: registered grant/enable/data,
// tenure capped at MAX_HOLD when others wait, TURN_CYCLES of release between owners.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int NUM_CH      = 4,
  parameter  int MAX_HOLD    = 8,
  parameter  int TURN_CYCLES = 1,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]       grant,
  output logic [CH_W-1:0]         owner,
  output logic                    bus_oe,
  output logic [WIDTH-1:0]        bus_out
);

  localparam int HOLD_W = ch_width(MAX_HOLD);
  localparam int TURN_W = ch_width(TURN_CYCLES);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

  bus_state_t          state, state_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_nx;
  logic [TURN_W-1:0]   turn_cnt, turn_nx;
  logic [CH_W-1:0]     rr_ptr, rr_nx;
  logic [NUM_CH-1:0]   grant_nx;
  logic [CH_W-1:0]     owner_nx;
  logic                oe_nx;
  logic [WIDTH-1:0]    out_nx;

  logic [WIDTH-1:0]    ch_data [NUM_CH];
  logic [NUM_CH-1:0]   pick_onehot;
  logic [CH_W-1:0]     pick_idx;
  logic                pick_any;
  logic                others_req;
  logic                owner_req;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_data[c] = data_in[c*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_any    (pick_any)
  );

  // grant is one-hot on the owner while driving, so masking it leaves the contenders
  assign others_req = |(req & ~grant);
  assign owner_req  = req[owner];

  // ---- next-state decode ----
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    turn_nx  = turn_cnt;
    rr_nx    = rr_ptr;
    grant_nx = grant;
    owner_nx = owner;
    oe_nx    = bus_oe;
    out_nx   = bus_out;

    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nx = ST_DRIVE;
          grant_nx = pick_onehot;
          owner_nx = pick_idx;
          oe_nx    = 1'b1;
          out_nx   = ch_data[pick_idx];
          hold_nx  = '0;
          rr_nx    = (pick_idx == CH_LAST) ? '0 : pick_idx + 1'b1;
        end
      end

      ST_DRIVE: begin
        if (!owner_req || (hold_cnt == HOLD_LAST && others_req)) begin
          // bus_out keeps the last driven word through the release window
          state_nx = ST_TURN;
          grant_nx = '0;
          oe_nx    = 1'b0;
          hold_nx  = '0;
          turn_nx  = '0;
        end else begin
          out_nx  = ch_data[owner];
          hold_nx = (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
        end
      end

      ST_TURN: begin
        if (turn_cnt == TURN_LAST) begin
          turn_nx = '0;
          if (pick_any) begin
            state_nx = ST_DRIVE;
            grant_nx = pick_onehot;
            owner_nx = pick_idx;
            oe_nx    = 1'b1;
            out_nx   = ch_data[pick_idx];
            hold_nx  = '0;
            rr_nx    = (pick_idx == CH_LAST) ? '0 : pick_idx + 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          turn_nx = turn_cnt + 1'b1;
        end
      end

      default: begin
        state_nx = ST_IDLE;
        grant_nx = '0;
        oe_nx    = 1'b0;
        hold_nx  = '0;
        turn_nx  = '0;
      end
    endcase
  end

  // ---- output and state registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      turn_cnt <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
      owner    <= '0;
      bus_oe   <= 1'b0;
      bus_out  <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      turn_cnt <= turn_nx;
      rr_ptr   <= rr_nx;
      grant    <= grant_nx;
      owner    <= owner_nx;
      bus_oe   <= oe_nx;
      bus_out  <= out_nx;
    end
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench for tri_bus_arbiter: stimulus pushes hand-computed expected
// outputs tagged with the cycle they must appear in; a negedge monitor compares.
module tb_tri_bus_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [31:0]  d [4];
  logic [127:0] data_in;

  logic [3:0]   grant0, grant1;
  logic [1:0]   owner0, owner1;
  logic         oe0, oe1;
  logic [31:0]  out0, out1;

  assign data_in = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  tri_bus_arbiter #(
    .WIDTH(32), .NUM_CH(4), .MAX_HOLD(8), .TURN_CYCLES(1)
  ) u_dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant0), .owner(owner0), .bus_oe(oe0), .bus_out(out0)
  );

  tri_bus_arbiter #(
    .WIDTH(32), .NUM_CH(4), .MAX_HOLD(8), .TURN_CYCLES(3)
  ) u_dut3 (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant1), .owner(owner1), .bus_oe(oe1), .bus_out(out1)
  );

  typedef struct {
    int          cyc;
    bit          sel;
    bit          use_snap;
    logic [3:0]  g;
    logic [1:0]  o;
    logic        oe;
    logic [31:0] dv;
    bit          chk_d;
    logic [3:0]  sg;
    logic [1:0]  so;
    logic        soe;
    logic [31:0] sd;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due this cycle and compares it.
  always @(negedge clk) begin
    logic [3:0]  ag;
    logic [1:0]  ao;
    logic        aoe;
    logic [31:0] ad;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.use_snap) begin
        ag = e.sg; ao = e.so; aoe = e.soe; ad = e.sd;
      end else if (e.sel) begin
        ag = grant1; ao = owner1; aoe = oe1; ad = out1;
      end else begin
        ag = grant0; ao = owner0; aoe = oe0; ad = out0;
      end
      n_chk++;
      if (e.cyc != cyc || ag !== e.g || ao !== e.o || aoe !== e.oe ||
          (e.chk_d && ad !== e.dv)) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got grant=%b owner=%0d oe=%b out=%h, required grant=%b owner=%0d oe=%b out=%h (data checked=%0d, due cyc %0d)",
                 e.name, cyc, ag, ao, aoe, ad, e.g, e.o, e.oe, e.dv, e.chk_d, e.cyc);
      end
    end
    if (done || cyc > 5000) begin
      if (q.size() != 0 || !done) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain: got %0d pending expectations, done=%0d, required 0 pending, done=1",
                 q.size(), done);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  // Apply req for this cycle; expected outputs appear after the next rising edge.
  task automatic drive(input logic [3:0] r, input bit s, input logic [3:0] g,
                       input logic [1:0] o, input logic oe, input logic [31:0] dv,
                       input bit cd, input string nm);
    exp_t x;
    req = r;
    x.cyc = cyc + 1; x.sel = s; x.use_snap = 1'b0;
    x.g = g; x.o = o; x.oe = oe; x.dv = dv; x.chk_d = cd;
    x.sg = '0; x.so = '0; x.soe = 1'b0; x.sd = '0; x.name = nm;
    q.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    exp_t x;
    reset = 1'b1;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) d[i] = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) drive(4'b0000, 0, 4'b0000, 2'd0, 1'b0, 32'h0, 1, "reset_idle");

    // Single requester ch1, then release -> one TURN cycle -> IDLE
    d[1] = 32'h00FF00FF;
    drive(4'b0010, 0, 4'b0010, 2'd1, 1'b1, 32'h00FF00FF, 1, "single_grant");
    drive(4'b0000, 0, 4'b0000, 2'd1, 1'b0, 32'h00FF00FF, 1, "single_turn");
    drive(4'b0000, 0, 4'b0000, 2'd1, 1'b0, 32'h0, 0, "single_idle");

    // Data tracking on ch1; ch0 data changes are ignored
    d[1] = 32'hFF00FF00; d[0] = 32'hAAAA0000;
    drive(4'b0010, 0, 4'b0010, 2'd1, 1'b1, 32'hFF00FF00, 1, "track_grant");
    d[1] = 32'h12345678;
    drive(4'b0010, 0, 4'b0010, 2'd1, 1'b1, 32'h12345678, 1, "track_step");
    d[0] = 32'h55555555;
    drive(4'b0010, 0, 4'b0010, 2'd1, 1'b1, 32'h12345678, 1, "track_other");
    d[1] = 32'hCAFEBABE;
    drive(4'b0010, 0, 4'b0010, 2'd1, 1'b1, 32'hCAFEBABE, 1, "track_step2");
    drive(4'b0000, 0, 4'b0000, 2'd1, 1'b0, 32'hCAFEBABE, 1, "track_turn");
    drive(4'b0000, 0, 4'b0000, 2'd1, 1'b0, 32'h0, 0, "track_idle");

    // Sole requester ch2 for 20 cycles: no turnaround at the MAX_HOLD wrap
    d[2] = 32'h22222222;
    for (int i = 0; i < 20; i++) drive(4'b0100, 0, 4'b0100, 2'd2, 1'b1, 32'h22222222, 1, "sole_hold");

    // Reset mid-DRIVE: outputs must clear before the next rising edge
    #2 reset = 1'b1;
    #1;
    x.cyc = cyc + 1; x.sel = 0; x.use_snap = 1'b1;
    x.g = 4'b0000; x.o = 2'd0; x.oe = 1'b0; x.dv = 32'h0; x.chk_d = 1;
    x.sg = grant0; x.so = owner0; x.soe = oe0; x.sd = out0; x.name = "async_reset";
    q.push_back(x);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0000;
    drive(4'b0000, 0, 4'b0000, 2'd0, 1'b0, 32'h0, 1, "post_reset");
    drive(4'b0000, 1, 4'b0000, 2'd0, 1'b0, 32'h0, 1, "post_reset_t3");

    // TURN_CYCLES=3 instance: ch0 releases while ch3 requests
    d[0] = 32'h0000AAAA; d[3] = 32'h3333CCCC;
    drive(4'b0001, 1, 4'b0001, 2'd0, 1'b1, 32'h0000AAAA, 1, "t3_grant");
    drive(4'b0001, 1, 4'b0001, 2'd0, 1'b1, 32'h0000AAAA, 1, "t3_hold");
    for (int i = 0; i < 3; i++) drive(4'b1000, 1, 4'b0000, 2'd0, 1'b0, 32'h0000AAAA, 1, "t3_turn");
    drive(4'b1000, 1, 4'b1000, 2'd3, 1'b1, 32'h3333CCCC, 1, "t3_next");
    drive(4'b0000, 1, 4'b0000, 2'd3, 1'b0, 32'h3333CCCC, 1, "t3_release");

    // Fresh reset, then all four request: ch0,ch1,ch2,ch3,ch0, 8 cycles each + 1 TURN
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 32'hC0DE0000 | i;
    for (int it = 0; it < 5; it++) begin
      logic [1:0]  k;
      logic [3:0]  oh;
      logic [31:0] dk;
      k  = 2'(it % 4);
      oh = 4'b0001 << k;
      dk = 32'hC0DE0000 | 32'(k);
      for (int c = 0; c < 8; c++) drive(4'b1111, 0, oh, k, 1'b1, dk, 1, "rr_drive");
      drive(4'b1111, 0, 4'b0000, k, 1'b0, dk, 1, "rr_turn");
    end
    drive(4'b0000, 0, 4'b0000, 2'd0, 1'b0, 32'h0, 0, "rr_idle");

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
Parametrised successor to the single-enable tri-state buffer. NUM_CH requesters share one WIDTH-bit bus. The block grants ownership round-robin, drives the selected channel's data with a registered output enable, caps each tenure at MAX_HOLD cycles, and inserts TURN_CYCLES of bus release between owners so two drivers never overlap. It sits between multiple bus masters and the shared bus wire; the bus_oe/bus_out pair feeds a top-level tri-state (bus = bus_oe ? bus_out : 'z).

Parameters:
WIDTH, 32, data width per channel and bus width
NUM_CH, 4, number of requesting channels (>=2)
MAX_HOLD, 8, maximum consecutive DRIVE cycles per grant when another channel is waiting (>=1)
TURN_CYCLES, 1, bus-release cycles between owners (>=1)

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
req  input  NUM_CH  per-channel bus request, level-sensitive
data_in  input  NUM_CH*WIDTH  flattened channel data; channel k at [k*WIDTH +: WIDTH]
grant  output  NUM_CH  one-hot owner, registered; all zero when bus released
owner  output  CH_W  binary index of current/last owner, registered (CH_W = max(1,$clog2(NUM_CH)))
bus_oe  output  1  registered output enable for the external tri-state
bus_out  output  WIDTH  registered bus drive data

Behaviour:
- Reset (async, active-high): state=IDLE, grant=0, owner=0, bus_oe=0, bus_out=0, hold_cnt=0, turn_cnt=0, rr_ptr=0. Arbitration resumes on the first rising edge after reset deasserts.
- States: IDLE, DRIVE, TURN.
- Round-robin: search starts at rr_ptr, wraps modulo NUM_CH; first set req bit wins. On each grant, rr_ptr <= winner+1 (wrap NUM_CH-1 -> 0).
- IDLE: bus_oe=0, grant=0. Any req set at edge -> DRIVE; grant, owner, bus_oe=1 and bus_out=data_in[winner] all take effect at that same edge. Request-to-drive latency is 1 cycle.
- DRIVE: bus_out <= data_in[owner] every cycle (1-cycle registered latency); hold_cnt increments each DRIVE cycle.
- DRIVE exit, req[owner]=0: -> TURN.
- DRIVE exit, hold_cnt reaches MAX_HOLD-1 and any other req set: -> TURN (pre-emption).
- DRIVE, hold_cnt reaches MAX_HOLD-1 with no other req: stay in DRIVE, hold_cnt reloads to 0, no turnaround.
- TURN: bus_oe=0, grant=0; owner and bus_out hold their last values. Lasts exactly TURN_CYCLES cycles. At the end: any req set -> DRIVE with a new round-robin winner (the previous owner may win if it is the only requester); otherwise -> IDLE.
- Invariants: at most one grant bit set. bus_oe==|grant. Between any two distinct owners, bus_oe is low for >=TURN_CYCLES cycles.
- Simultaneous requests: round-robin order only; no fixed priority except from reset (rr_ptr=0, so ch0 wins first).
- req deasserted and reasserted in the same TURN window: treated as a fresh request.
- Reset mid-DRIVE: bus_oe drops asynchronously, with no turnaround required.
- data_in of non-owners is ignored.

Decomposition:
- Shared package tri_bus_pkg: state encoding (IDLE/DRIVE/TURN), CH_W derivation function.
- One sub-module, rr_arbiter: combinational round-robin pick from (req, rr_ptr) -> one-hot winner plus index, parametrised by NUM_CH. Reusable by later bus blocks.
- FSM, counters and output registers live in tri_bus_arbiter.

Test Plan:
- Reset, no req: grant=0, bus_oe=0, bus_out=0 for 10 cycles. Assert reset mid-DRIVE -> bus_oe=0 asynchronously, before the next edge.
- Single requester: req=4'b0010, data_in ch1=32'h00FF00FF -> next cycle grant=0010, owner=1, bus_oe=1, bus_out=32'h00FF00FF; drop req -> 1 TURN cycle with bus_oe=0 -> IDLE.
- All four request from reset -> grant sequence ch0,ch1,ch2,ch3,ch0, each tenure 8 cycles (MAX_HOLD=8), each followed by exactly 1 cycle bus_oe=0.
- Sole requester ch2 held 20 cycles -> bus_oe stays 1 continuously, no TURN, grant=0100 throughout.
- TURN_CYCLES=3 build: ch0 releases while ch3 requests -> bus_oe low exactly 3 cycles, then grant=1000, bus_out=data_in ch3.
- Data tracking: owner ch1, data_in ch1 steps 32'hFF00FF00 -> 32'h12345678 -> bus_out follows one cycle later. Changing ch0 data meanwhile has no effect on bus_out.
